mux_scan_ctrl: RTL

Sequential scan controller that sits directly upstream of the 31-input, 2-bit selection mux. On a start request it drives the mux's 5-bit select through a programmable index range, one index per clock. It captures each 2-bit mux output into a packed result register and reports completion with a done pulse. It lets the rest of the design snapshot all mux inputs without driving `sel` by hand.

---
 rtl/mux_scan_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 31:1 mux select through an index range
// and packs every 2-bit mux output into a result register.
module mux_scan_ctrl #(
  parameter int NUM_INP = 31,
  parameter int SEL_W   = 5,
  parameter int DATA_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [SEL_W-1:0]          first_idx,
  input  logic [SEL_W-1:0]          last_idx,
  output logic [SEL_W-1:0]          mux_sel,
  input  logic [DATA_W-1:0]         mux_out,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [NUM_INP*DATA_W-1:0] scan_data,
  output logic [NUM_INP-1:0]        scan_mask,
  output logic [SEL_W-1:0]          nz_count
);

  localparam logic [SEL_W-1:0] PARK_SEL = '1;
  localparam logic [SEL_W-1:0] MAX_IDX  = SEL_W'(NUM_INP - 1);
  localparam logic [SEL_W-1:0] NZ_SAT   = '1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t                      state;
  logic [SEL_W-1:0]            last_q;
  logic                        legal;
  logic                        at_last;
  logic                        nz;
  logic [NUM_INP*DATA_W-1:0]   cap_data;
  logic [NUM_INP-1:0]          cap_mask;

  // range check and per-cycle capture flags
  always_comb begin
    legal   = (first_idx <= last_idx) &&
              (last_idx <= MAX_IDX);
    at_last = (mux_sel == last_q);
    nz      = (mux_out != '0);
  end

  // results with the current mux output merged in at mux_sel
  always_comb begin
    cap_data = scan_data;
    cap_mask = scan_mask;
    for (int i = 0; i < NUM_INP; i++) begin
      if (mux_sel == SEL_W'(i)) begin
        cap_data[i*DATA_W +: DATA_W] = mux_out;
        cap_mask[i] = 1'b1;
      end
    end
  end

  // scan state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_q    <= '0;
      mux_sel   <= PARK_SEL;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      scan_data <= '0;
      scan_mask <= '0;
      nz_count  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              last_q    <= last_idx;
              scan_data <= '0;
              scan_mask <= '0;
              nz_count  <= '0;
              mux_sel   <= first_idx;
              busy      <= 1'b1;
              state     <= SCAN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            mux_sel <= PARK_SEL;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            scan_data <= cap_data;
            scan_mask <= cap_mask;
            if (nz && nz_count != NZ_SAT)
              nz_count <= nz_count + 1'b1;
            if (at_last) begin
              mux_sel <= PARK_SEL;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              mux_sel <= mux_sel + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mux_sel <= PARK_SEL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
